// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: scatters a signed immediate into I/S/SB/J fields.
// Define IMMENC_RANGE_CHECK_EN to build the representability check and error counter.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instruction,
  input  logic [1:0]  immSel,
  input  logic [31:0] immValue,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instOut,
  output logic        immErr,
  output logic [7:0]  errCount
);

  logic        s1_valid;
  logic [31:0] s1_inst;
  logic [1:0]  s1_sel;
  logic [31:0] s1_imm;
  logic        s2_valid;
  logic [31:0] s2_inst;
  logic        s2_will_load;
  logic        in_fire;
  logic [31:0] merged;

  function automatic logic [31:0] merge(
    input logic [31:0] b,
    input logic [1:0]  s,
    input logic [31:0] m
  );
    logic [31:0] r;
    r = b;
    unique case (1'b1)
      (s == 2'b00): r[31:20] = m[11:0];
      (s == 2'b01): begin
        r[31:25] = m[11:5];
        r[11:7]  = m[4:0];
      end
      (s == 2'b10): begin
        r[31]    = m[12];
        r[7]     = m[11];
        r[30:25] = m[10:5];
        r[11:8]  = m[4:1];
      end
      default: begin
        r[31]    = m[20];
        r[19:12] = m[19:12];
        r[20]    = m[11];
        r[30:21] = m[10:1];
      end
    endcase
    return r;
  endfunction

  assign s2_will_load = s1_valid && (!s2_valid || out_ready);
  assign in_ready     = !rst && (!s1_valid || s2_will_load);
  assign in_fire      = in_valid && in_ready;
  assign merged       = merge(s1_inst, s1_sel, s1_imm);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_inst  <= '0;
      s1_sel   <= '0;
      s1_imm   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_inst  <= instruction;
      s1_sel   <= immSel;
      s1_imm   <= immValue;
    end else if (s2_will_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_inst  <= '0;
    end else if (s2_will_load) begin
      s2_valid <= 1'b1;
      s2_inst  <= merged;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign instOut   = s2_inst;

`ifdef IMMENC_RANGE_CHECK_EN
  logic       s1_err;
  logic       s2_err;
  logic [7:0] err_cnt;

  // Upper bits must be a pure sign extension; branch/jump offsets must be even.
  function automatic logic bad_imm(input logic [1:0] s, input logic [31:0] m);
    logic r;
    unique case (1'b1)
      (s == 2'b10): r = !((&m[31:12]) || !(|m[31:12])) || m[0];
      (s == 2'b11): r = !((&m[31:20]) || !(|m[31:20])) || m[0];
      default:      r = !((&m[31:11]) || !(|m[31:11]));
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_err <= 1'b0;
    end else if (in_fire) begin
      s1_err <= bad_imm(immSel, immValue);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_err <= 1'b0;
    end else if (s2_will_load) begin
      s2_err <= s1_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && s2_err && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign immErr   = s2_err;
  assign errCount = err_cnt;
`else
  assign immErr   = 1'b0;
  assign errCount = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors, backpressure, reset flush.
// Expected error values follow IMMENC_RANGE_CHECK_EN in the same build.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [1:0]  immSel;
  logic [31:0] immValue;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instOut;
  logic        immErr;
  logic [7:0]  errCount;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

`ifdef IMMENC_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  imm_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .immSel(immSel), .immValue(immValue),
    .out_valid(out_valid), .out_ready(out_ready),
    .instOut(instOut), .immErr(immErr), .errCount(errCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: inputs only change 1ns after posedge, so negedge sees the transfer state.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out got=0x%08h err=%0b", instOut, immErr);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({immErr, instOut} !== e) begin
          failures++;
          $display("FAIL out_word got=0x%08h err=%0b expected=0x%08h err=%0b",
                   instOut, immErr, e[31:0], e[32]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [1:0] sel,
                      input logic [31:0] imm, input logic [31:0] exp_inst,
                      input logic err);
    bit rdy;
    in_valid    = 1'b1;
    instruction = ins;
    immSel      = sel;
    immValue    = imm;
    for (int t = 0; t < 50; t++) begin
      #1 rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        exp_q.push_back({err & CHK, exp_inst});
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL send_timeout inst=0x%08h", ins);
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    instruction = '0;
    immSel = '0;
    immValue = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_instOut", instOut, 0);
    check("rst_immErr", immErr, 0);
    check("rst_errCount", errCount, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("in_ready_after_rst", in_ready, 1);

    // I-type with latency probe
    @(posedge clk);
    #1;
    send(32'h00000013, 2'b00, 32'hFFFFFFFF, 32'hFFF00013, 1'b0);
    idle();
    @(negedge clk);
    check("lat_edge_n", out_valid, 0);
    @(negedge clk);
    check("lat_edge_n1", out_valid, 1);
    drain();

    // S, SB, J back to back
    send(32'h00002023, 2'b01, 32'h000007FF, 32'h7E002FA3, 1'b0);
    send(32'h00000063, 2'b10, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    send(32'h0000006F, 2'b11, 32'h00000800, 32'h0010006F, 1'b0);
    idle();
    drain();
    check("errcnt_clean", errCount, 0);

    // Error vectors
    send(32'h00000063, 2'b10, 32'h00000003, 32'h00000163, 1'b1);
    idle();
    drain();
    check("errcnt_one", errCount, CHK ? 1 : 0);
    send(32'h00000013, 2'b00, 32'h00000800, 32'h80000013, 1'b1);
    idle();
    drain();
    check("errcnt_two", errCount, CHK ? 2 : 0);

    // Saturation
    for (int i = 0; i < 300; i++)
      send(32'h00000063, 2'b10, 32'h00000003, 32'h00000163, 1'b1);
    idle();
    drain();
    check("errcnt_sat", errCount, CHK ? 255 : 0);

    // Backpressure: two accepted, third stalls
    out_ready = 1'b0;
    send(32'h00000013, 2'b00, 32'h1, 32'h00100013, 1'b0);
    send(32'h00000013, 2'b00, 32'h2, 32'h00200013, 1'b0);
    in_valid = 1'b1;
    instruction = 32'h00000013;
    immValue = 32'h3;
    #1 check("bp_stall_a", in_ready, 0);
    @(posedge clk);
    #2 check("bp_stall_b", in_ready, 0);
    check("bp_hold_inst", instOut, 32'h00100013);
    out_ready = 1'b1;
    send(32'h00000013, 2'b00, 32'h3, 32'h00300013, 1'b0);
    idle();
    @(negedge clk);
    check("bp_stream_2", out_valid, 1);
    @(negedge clk);
    check("bp_stream_3", out_valid, 1);
    @(negedge clk);
    check("bp_stream_end", out_valid, 0);
    check("bp_all_out", exp_q.size(), 0);

    // Reset with two words in flight
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'h00000013, 2'b00, 32'h00000800, 32'h80000013, 1'b1);
    send(32'h00000013, 2'b00, 32'h5, 32'h00500013, 1'b0);
    idle();
    rst = 1'b1;
    out_ready = 1'b1;
    exp_q.delete();
    #1 check("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_errCount", errCount, 0);
    check("mid_rst_in_ready1", in_ready, 1);
    repeat (6) @(posedge clk);
    #1 check("mid_rst_no_stale", exp_q.size(), 0);
    check("mid_rst_idle", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
